// File: rtl/mult_seq_ctrl.sv
// Start-button synchronizer plus iterative shift-add multiplier (one partial product per clock)
// that presents a held 2*WIDTH-bit value to the hex display decoder.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_n,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [2*WIDTH-1:0] disp_value
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_s1;
  logic            r_s2;
  logic            r_s3;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [PW-1:0]   r_result;

  logic            w_start;
  logic [PW-1:0]   w_partial;
  logic [PW-1:0]   w_acc_next;

  // Press edge only: a held button yields a single event.
  assign w_start    = r_s3 & ~r_s2;
  assign w_partial  = r_mplr[0] ? r_mcand : {PW{1'b0}};
  assign w_acc_next = r_acc + w_partial;

  // Two-flop synchronizer for the raw button plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= start_n;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Sequencing FSM with datapath; busy/done/result are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= {PW{1'b0}};
      r_mplr   <= {WIDTH{1'b0}};
      r_acc    <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {PW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (w_start) begin
            r_mcand <= {{WIDTH{1'b0}}, a_in};
            r_mplr  <= b_in;
            r_acc   <= {PW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc   <= w_acc_next;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + CW'(1);
          // Final iteration's add goes straight into result.
          if (r_cnt == LAST_CNT) begin
            r_result <= w_acc_next;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Live switches while idle; otherwise the held product (never the partial acc).
  always_comb begin
    disp_value = r_result;
    if (r_state == ST_IDLE) begin
      disp_value = {a_in, b_in};
    end else begin
      disp_value = r_result;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios plus randomized operands
// checked against plain integer multiplication.
module tb_mult_seq_ctrl;
  logic        clk;
  logic        reset_n;
  logic        start_n;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] disp_value;

  int vectors;
  int miscompares;

  // Per-window stimulus controls (0 = unused) and observations.
  int          hold_len;
  int          repress_at;
  logic [7:0]  repress_a;
  int          rst_at;
  logic [15:0] calc_disp_exp;
  int          first_busy, busy_cycles, done_cycles, done_at, overlap, disp_bad;
  logic [15:0] res_at_done, disp_at_done;

  mult_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_n(start_n), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .disp_value(disp_value)
  );

  always #5 clk = ~clk;

  // Steps ncyc falling edges after a press applied at the current falling edge.
  // Sample n reflects rising edge k+n-1 where k is the first edge seeing start_n low.
  task automatic run_window(input int ncyc);
    first_busy = 0; busy_cycles = 0; done_cycles = 0; done_at = 0; overlap = 0; disp_bad = 0;
    res_at_done = 16'hxxxx; disp_at_done = 16'hxxxx;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cycles++;
        if (first_busy == 0) first_busy = n;
        if (disp_value !== calc_disp_exp) disp_bad++;
      end
      if (done === 1'b1) begin
        done_cycles++;
        done_at = n;
        res_at_done = result;
        disp_at_done = disp_value;
      end
      if (busy === 1'b1 && done === 1'b1) overlap++;
      if (n == hold_len) start_n = 1'b1;
      if (repress_at != 0 && n == repress_at) begin
        start_n = 1'b0;
        a_in = repress_a;
      end
      if (rst_at != 0 && n == rst_at) reset_n = 1'b0;
      if (rst_at != 0 && n == rst_at + 1) reset_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_n = 1'b1; a_in = 8'h12; b_in = 8'h34;
    repeat (3) @(negedge clk);
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h want 0000", result); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (disp_value !== 16'h1234) begin miscompares++; $display("FAIL reset_disp: got %h want 1234", disp_value); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    a_in = 8'hA5; b_in = 8'h3C;
    #1;
    vectors++; if (disp_value !== 16'hA53C) begin miscompares++; $display("FAIL idle_disp_live: got %h want a53c", disp_value); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    a_in = 8'h0C; b_in = 8'h0A; calc_disp_exp = 16'h0000;
    hold_len = 2; repress_at = 0; rst_at = 0;
    start_n = 1'b0;
    run_window(16);
    vectors++; if (first_busy !== 3) begin miscompares++; $display("FAIL basic_busy_rise: got %0d want 3", first_busy); end
    vectors++; if (busy_cycles !== 8) begin miscompares++; $display("FAIL basic_busy_len: got %0d want 8", busy_cycles); end
    vectors++; if (done_cycles !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", done_cycles); end
    vectors++; if (done_at !== 11) begin miscompares++; $display("FAIL basic_done_time: got %0d want 11", done_at); end
    vectors++; if (res_at_done !== 16'h0078) begin miscompares++; $display("FAIL basic_result: got %h want 0078", res_at_done); end
    vectors++; if (disp_at_done !== 16'h0078) begin miscompares++; $display("FAIL basic_disp: got %h want 0078", disp_at_done); end
    vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL basic_overlap: got %0d want 0", overlap); end
    vectors++; if (disp_bad !== 0) begin miscompares++; $display("FAIL basic_calc_disp: got %0d bad want 0", disp_bad); end
    a_in = 8'h55;
    #1;
    vectors++; if (disp_value !== 16'h0078) begin miscompares++; $display("FAIL basic_done_hold: got %h want 0078", disp_value); end
  endtask

  task automatic test_extremes();
    logic [7:0] av [2];
    logic [7:0] bv [2];
    logic [15:0] prev;
    av[0] = 8'hFF; bv[0] = 8'hFF;
    av[1] = 8'h00; bv[1] = 8'hFF;
    prev = 16'h0078;
    for (int i = 0; i < 2; i++) begin
      a_in = av[i]; b_in = bv[i]; calc_disp_exp = prev;
      hold_len = 2; repress_at = 0; rst_at = 0;
      start_n = 1'b0;
      run_window(16);
      prev = 16'(av[i]) * 16'(bv[i]);
      vectors++; if (res_at_done !== prev) begin miscompares++; $display("FAIL extreme_result[%0d]: got %h want %h", i, res_at_done, prev); end
      vectors++; if (busy_cycles !== 8) begin miscompares++; $display("FAIL extreme_busy_len[%0d]: got %0d want 8", i, busy_cycles); end
      vectors++; if (done_cycles !== 1) begin miscompares++; $display("FAIL extreme_done_count[%0d]: got %0d want 1", i, done_cycles); end
      vectors++; if (disp_bad !== 0) begin miscompares++; $display("FAIL extreme_calc_disp[%0d]: got %0d bad want 0", i, disp_bad); end
    end
  endtask

  task automatic test_ignored_start();
    a_in = 8'h03; b_in = 8'h05; calc_disp_exp = 16'h0000;
    hold_len = 2; repress_at = 6; repress_a = 8'h09; rst_at = 0;
    start_n = 1'b0;
    run_window(30);
    start_n = 1'b1;
    vectors++; if (res_at_done !== 16'h000F) begin miscompares++; $display("FAIL ignored_result: got %h want 000f", res_at_done); end
    vectors++; if (done_cycles !== 1) begin miscompares++; $display("FAIL ignored_done_count: got %0d want 1", done_cycles); end
    vectors++; if (busy_cycles !== 8) begin miscompares++; $display("FAIL ignored_busy_len: got %0d want 8", busy_cycles); end
    repeat (4) @(negedge clk);
    vectors++; if (result !== 16'h000F) begin miscompares++; $display("FAIL ignored_final: got %h want 000f", result); end
  endtask

  task automatic test_restart_hold();
    a_in = 8'h10; b_in = 8'h10; calc_disp_exp = 16'h000F;
    hold_len = 50; repress_at = 0; rst_at = 0;
    start_n = 1'b0;
    run_window(60);
    vectors++; if (done_cycles !== 1) begin miscompares++; $display("FAIL hold_done_count: got %0d want 1", done_cycles); end
    vectors++; if (busy_cycles !== 8) begin miscompares++; $display("FAIL hold_busy_len: got %0d want 8", busy_cycles); end
    vectors++; if (res_at_done !== 16'h0100) begin miscompares++; $display("FAIL hold_result: got %h want 0100", res_at_done); end
    vectors++; if (disp_bad !== 0) begin miscompares++; $display("FAIL hold_calc_disp: got %0d bad want 0", disp_bad); end
  endtask

  task automatic test_reset_abort();
    a_in = 8'h21; b_in = 8'h07; calc_disp_exp = 16'h0100;
    hold_len = 2; repress_at = 0; rst_at = 7;
    start_n = 1'b0;
    run_window(20);
    vectors++; if (done_cycles !== 0) begin miscompares++; $display("FAIL abort_done_count: got %0d want 0", done_cycles); end
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL abort_result: got %h want 0000", result); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    vectors++; if (disp_value !== 16'h2107) begin miscompares++; $display("FAIL abort_idle_disp: got %h want 2107", disp_value); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ra, rb;
    logic [15:0] prev, want;
    prev = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      a_in = ra; b_in = rb; calc_disp_exp = prev;
      hold_len = 2; repress_at = 0; rst_at = 0;
      start_n = 1'b0;
      run_window(14);
      want = 16'(ra) * 16'(rb);
      vectors++; if (res_at_done !== want) begin miscompares++; $display("FAIL rand_result[%0d] %h*%h: got %h want %h", i, ra, rb, res_at_done, want); end
      vectors++; if (done_at !== 11) begin miscompares++; $display("FAIL rand_done_time[%0d]: got %0d want 11", i, done_at); end
      vectors++; if (disp_bad !== 0 || overlap !== 0) begin miscompares++; $display("FAIL rand_disp_overlap[%0d]: got %0d/%0d want 0/0", i, disp_bad, overlap); end
      prev = want;
    end
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; start_n = 1'b1; a_in = 8'h00; b_in = 8'h00;
    vectors = 0; miscompares = 0;
    hold_len = 0; repress_at = 0; repress_a = 8'h00; rst_at = 0; calc_disp_exp = 16'h0000;
    test_reset();
    test_basic();
    test_extremes();
    test_ignored_start();
    test_restart_hold();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
